// File: rtl/instruction_encoder.sv
// instruction_encoder: packs RV32 instruction fields into 32-bit words with range checking and address tagging
module instruction_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_format,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        out_err
);
  typedef enum logic [1:0] {IDLE, CHECK, HOLD} state_t;
  state_t state;
  logic [2:0] fmt, f3;
  logic [6:0] op, f7;
  logic [4:0] rd, rs1, rs2;
  logic [31:0] imm, addr, enc;
  logic err, shift, fit12, fit13, fit21;
  assign in_ready = state == IDLE && !rst;
  assign out_addr = addr;
  assign shift = op == 7'h13 && (f3 == 3'b001 || f3 == 3'b101);
  // an immediate fits n signed bits when everything above bit n-2 is a copy of the sign
  assign fit12 = &imm[31:11] | ~|imm[31:11];
  assign fit13 = &imm[31:12] | ~|imm[31:12];
  assign fit21 = &imm[31:20] | ~|imm[31:20];
  always_comb begin
    enc = 32'h0000_0013;
    err = 1'b0;
    case (fmt)
      3'd0: enc = {f7, rs2, rs1, f3, rd, op};
      3'd1: begin
        enc = shift ? {f7, imm[4:0], rs1, f3, rd, op} : {imm[11:0], rs1, f3, rd, op};
        err = shift ? |imm[31:5] : !fit12;
      end
      3'd2: begin
        enc = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
        err = !fit12;
      end
      3'd3: begin
        enc = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
        err = !fit13 | imm[0];
      end
      3'd4: begin
        enc = {imm[31:12], rd, op};
        err = |imm[11:0];
      end
      3'd5: begin
        enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
        err = !fit21 | imm[0];
      end
      default: err = 1'b1;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      out_valid <= 1'b0;
      out_err <= 1'b0;
      out_instr <= 32'h0;
      addr <= BASE_ADDR;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          fmt <= in_format;
          op <= in_opcode;
          f3 <= in_funct3;
          f7 <= in_funct7;
          rd <= in_rd;
          rs1 <= in_rs1;
          rs2 <= in_rs2;
          imm <= in_imm;
          state <= CHECK;
        end
        CHECK: begin
          out_instr <= err ? 32'h0000_0013 : enc;
          out_err <= err;
          out_valid <= 1'b1;
          state <= HOLD;
        end
        HOLD: if (out_ready) begin
          out_valid <= 1'b0;
          addr <= addr + 32'd4;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/instruction_encoder.md
INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the byte address assigned to the first encoded instruction after reset.
REQ-002 SHALL have port clk  in  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  in  1  encode request present.
REQ-005 SHALL have port in_ready  out  1  encoder can accept a request.
REQ-006 SHALL have port in_format  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
REQ-007 SHALL have ports in_opcode  in  7, in_funct3  in  3, in_funct7  in  7, carrying the instruction fields.
REQ-008 SHALL have ports in_rd, in_rs1, in_rs2  in  5 each, carrying the register indices.
REQ-009 SHALL have port in_imm  in  32  full-width signed immediate; for U format, the final value with bits [11:0] zero.
REQ-010 SHALL have port out_valid  out  1  encoded word present.
REQ-011 SHALL have port out_ready  in  1  consumer accepts the word.
REQ-012 SHALL have port out_instr  out  32  encoded instruction.
REQ-013 SHALL have port out_addr  out  32  byte address of out_instr.
REQ-014 SHALL have port out_err  out  1  request was illegal or its immediate is unrepresentable.

Function
REQ-015 SHALL implement FSM IDLE -> CHECK -> HOLD -> IDLE; in_ready = 1 only in IDLE.
REQ-016 SHALL, in IDLE, register all in_* fields and go to CHECK on in_valid; otherwise stay in IDLE.
REQ-017 SHALL, in CHECK, compute out_instr and out_err from the registered fields and go to HOLD unconditionally.
REQ-018 SHALL set out_valid = 1 only in HOLD; a request accepted at edge N SHALL show out_valid at edge N+2.
REQ-019 SHALL hold out_instr, out_addr and out_err stable in HOLD until out_valid and out_ready are both high, then return to IDLE.
REQ-020 SHALL encode R as funct7[31:25], rs2[24:20], rs1[19:15], funct3[14:12], rd[11:7], opcode[6:0].
REQ-021 SHALL encode I as imm[11:0] in [31:20], with rs1, funct3, rd and opcode placed as in R.
REQ-022 SHALL treat I shifts (opcode 7'h13 with funct3 3'b001 or 3'b101) as follows: [31:25] = funct7, [24:20] = imm[4:0], legal only if imm is 0..31.
REQ-023 SHALL encode S as imm[11:5] in [31:25] and imm[4:0] in [11:7], with rs2, rs1, funct3 and opcode placed as in R.
REQ-024 SHALL encode B as [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11], with rs2, rs1, funct3 and opcode placed as in R.
REQ-025 SHALL encode U as imm[31:12] in [31:12], with rd and opcode.
REQ-026 SHALL encode J as [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12], with rd and opcode.
REQ-027 SHALL apply these range rules, setting out_err = 1 on violation:
- I and S: imm in -2048..2047.
- B: imm in -4096..4094 and imm[0] = 0.
- J: imm in -1048576..1048574 and imm[0] = 0.
- U: imm[11:0] = 0.
- R: imm ignored; never an error.
REQ-028 SHALL set out_err = 1 for in_format 6 or 7.
REQ-029 SHALL, whenever out_err = 1, drive out_instr = 32'h0000_0013 (nop).
REQ-030 SHALL increment the address register by 4 on every output handshake, including error words, wrapping modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-031 SHALL drive out_addr from the address register.

Reset
REQ-032 SHALL, when rst is high at a rising edge, force the following regardless of state:
- FSM = IDLE.
- out_valid = 0, out_err = 0, out_instr = 32'h0.
- address register = BASE_ADDR.
REQ-033 SHALL discard any request in CHECK or HOLD when reset occurs mid-operation; the next accepted request gets address BASE_ADDR.
REQ-034 SHALL hold in_ready = 0 during the reset cycle and in_ready = 1 on the first cycle after reset is released.

Verification
REQ-035 SHALL cover: I format, opcode 7'h13, rd=1, rs1=2, funct3=0, imm=-1 -> out_instr 32'hFFF1_0093, out_err 0, out_addr BASE_ADDR, valid at N+2.
REQ-036 SHALL cover: B format, opcode 7'h63, rs1=1, rs2=2, funct3=0, imm=-4 -> 32'hFE20_8EE3; then imm=3 -> out_err 1, out_instr 32'h0000_0013.
REQ-037 SHALL cover: J format, opcode 7'h6F, rd=1, imm=2048 -> 32'h0010_00EF; then U format, opcode 7'h37, imm=32'h1234_5001 -> out_err 1.
REQ-038 SHALL cover: out_ready held low 5 cycles in HOLD -> outputs stable, in_ready 0; release -> address advances by 4.
REQ-039 SHALL cover: BASE_ADDR=32'hFFFF_FFFC, two requests -> out_addr FFFF_FFFC, then 0000_0000.
REQ-040 SHALL cover: rst asserted during HOLD -> out_valid 0 next cycle; next request -> out_addr BASE_ADDR.
